minilogix_loader: RTL and testbench
===================================

# minilogix_loader

Configuration controller for the `minilogix1` programmable logic block. It accepts the LUT/RAM image and the input-select word as a byte stream over a valid/ready handshake and serialises it into the block's `i_load_en`/`i_load_clk`/`i_load_dat` shift-load port. It generates the slow load clock itself and holds the logic block out of run mode while loading. It sits between the chip-level byte interface (host SPI/parallel bridge) and one `minilogix1` instance.

## Interface
Parameters:
- `NIN`, 8, logic block input count
- `NOUT`, 8, logic block output count
- `HALF`, 1, load-clock half period in `clk` cycles (≥1)
- Derived: `NCFG = min(NIN,NOUT)`, `NBITS = NOUT*2**NIN + NCFG`, `NBYTES = ceil(NBITS/8)`, `REM = NBITS mod 8`

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `i_start`  in  1  begin a load; honoured only in IDLE
- `i_abort`  in  1  abandon the load in progress
- `i_byte_dat`  in  8  config byte, MSB shifted first
- `i_byte_valid`  in  1  byte present
- `o_byte_ready`  out  1  loader accepts a byte this cycle
- `o_load_en`  out  1  to `minilogix1.i_load_en`
- `o_load_clk`  out  1  to `minilogix1.i_load_clk`
- `o_load_dat`  out  1  to `minilogix1.i_load_dat`
- `o_busy`  out  1  load in progress
- `o_done`  out  1  one-cycle pulse, load complete
- `o_cfg_valid`  out  1  sticky: full image loaded
- `o_run_en`  out  1  enable for the logic block's feedback clock (= `o_cfg_valid`)

## Operation
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- States: IDLE, WAIT_BYTE, SHIFT_LO, SHIFT_HI, DONE.
- IDLE, with `i_start`=1: clear `o_cfg_valid`, clear the bit counter, set `o_busy`=1 and `o_load_en`=1, then go to WAIT_BYTE.
- WAIT_BYTE: `o_byte_ready`=1 and `o_load_clk`=0.
  - On `valid&&ready`, latch the byte into the 8-bit shift register.
  - Bits in this byte = 8, except the last byte when REM≠0, which uses REM bits (the upper REM bits; the lower bits are ignored).
  - Go to SHIFT_LO.
  - With no valid byte, wait indefinitely; there is no timeout.
- SHIFT_LO: `o_load_dat`=sreg[7], `o_load_clk`=0 for HALF cycles, then go to SHIFT_HI.
- SHIFT_HI: `o_load_clk`=1 for HALF cycles, with `o_load_dat` held stable. On exit, increment the bit counter and shift sreg left. Then:
  - if bit counter = NBITS, go to DONE;
  - else if bits remain in this byte, go to SHIFT_LO;
  - else go to WAIT_BYTE.
- DONE (one cycle): `o_done`=1, `o_cfg_valid`=1, `o_load_en`=0, `o_busy`=0, then go to IDLE.
- Bit order: the first bit shifted lands at the top of the block's RAM, which is the input-select word MSB. The stream is therefore the select word (MSB first), then RAM word 2**NIN−1 down to word 0, each MSB first.
- `i_abort` in any non-IDLE state: go to IDLE next cycle. `o_load_en`, `o_load_clk`, `o_busy`, `o_byte_ready` and `o_cfg_valid` are all 0. The partial image is discarded.
- `i_abort` takes priority over a byte handshake in the same cycle, so the byte is not consumed (`o_byte_ready` is forced 0 when `i_abort`=1).
- `i_start` while busy is ignored. `i_start` and `i_abort` together in IDLE: abort wins and no load starts.
- Bit counter width is `$clog2(NBITS+1)` and never wraps. The half-period counter is `$clog2(HALF+1)` bits wide.
- Asserting `rst_n` low mid-load immediately returns all outputs to 0 (`o_load_clk` low, with no glitch-high on release).

## Timing
- `i_start` at edge n gives `o_busy`/`o_load_en`=1 and `o_byte_ready`=1 after edge n+1.
- Byte accepted at edge m gives the first `o_load_clk` rise after edge m+1+HALF.
- Per bit: 2·HALF cycles. Per byte with `i_byte_valid` held high: 1 + 8·2·HALF cycles.
- Defaults (NBITS=2056, NBYTES=257, HALF=1): 257·17 = 4369 cycles from first `o_byte_ready` to `o_done`.
- `o_load_dat` changes only in SHIFT_LO entry, at least HALF cycles before the `o_load_clk` rise, giving setup and hold of ≥HALF `clk` cycles.

## Structure
- Shared package `minilogix_pkg`:
  - state encoding (3-bit localparams IDLE=0, WAIT_BYTE=1, SHIFT_LO=2, SHIFT_HI=3, DONE=4);
  - `NBITS`/`NBYTES`/`REM` helper functions used by both this block and the bench.
- Single natural sub-module: `minilogix_ser`, the HALF-period divider plus 8-bit shift register with a bits-in-byte count. The FSM and bit counter stay in the top module.

## Test plan
- NIN=2, NOUT=2, HALF=1 (NBITS=10, 2 bytes, REM=2). Bytes 0xA5 then 0xC0 → 10 `o_load_clk` rises with data 1,0,1,0,0,1,0,1,1,1; attached `minilogix1` ram_r = 10'b1010010111; `o_done` one pulse; `o_cfg_valid`=1.
- Defaults with a random 257-byte image streamed back-to-back → `o_done` exactly 4369 cycles after the first `o_byte_ready`; applying input 8'h3C with select word 0 gives the expected RAM word on `o_output`.
- `i_byte_valid` withheld for 20 cycles after byte 1 → `o_load_clk` stays 0, `o_load_en` stays 1, no extra rises; the load completes correctly afterwards.
- `i_abort` after 5 bits, with a simultaneous valid byte → next cycle all outputs 0; the byte is not consumed; `o_cfg_valid`=0; a new `i_start` reloads the full image cleanly.
- `rst_n` low for 1 cycle mid SHIFT_HI → `o_load_clk` immediately 0 and all outputs 0; `i_start` during busy has no effect (counter unchanged).
- HALF=3 → each `o_load_clk` high/low phase is exactly 3 cycles; `o_load_dat` is stable for 3 cycles before each rise.

Source files
------------

// File: rtl/minilogix_pkg.sv
// Shared definitions for the minilogix configuration loader: FSM encoding and
// image-geometry helpers.
package minilogix_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitByte = 3'd1,
    StShiftLo  = 3'd2,
    StShiftHi  = 3'd3,
    StDone     = 3'd4
  } state_e;

  // Image = select word (min(nin,nout) bits) followed by the full RAM.
  function automatic int unsigned calc_nbits(input int unsigned nin, input int unsigned nout);
    int unsigned ncfg;
    ncfg = (nin < nout) ? nin : nout;
    return nout * (32'd1 << nin) + ncfg;
  endfunction

  function automatic int unsigned calc_nbytes(input int unsigned nbits);
    return (nbits + 32'd7) / 32'd8;
  endfunction

  function automatic int unsigned calc_rem(input int unsigned nbits);
    return nbits % 32'd8;
  endfunction

endpackage

// File: rtl/minilogix_ser.sv
// Load-clock half-period divider plus the 8-bit MSB-first shift register that
// feeds the logic block's serial load port.
module minilogix_ser #(
  parameter int unsigned HALF = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] byte_dat,
  input  logic [3:0] byte_bits,
  input  logic       shift,
  output logic       phase_end,
  output logic       msb_next,
  output logic       last_bit
);

  localparam int unsigned CntW = $clog2(HALF + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF - 1);

  logic [CntW-1:0] cnt_q;
  logic [7:0]      sreg_q;
  logic [3:0]      left_q;

  assign phase_end = run && (cnt_q == HalfLast);
  assign last_bit  = (left_q == 4'd1);
  // Bit that sreg[7] will hold after this edge, so the top can register it on SHIFT_LO entry.
  assign msb_next  = load ? byte_dat[7] : (shift ? sreg_q[6] : sreg_q[7]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sreg_q <= '0;
      left_q <= '0;
    end else begin
      if (!run || phase_end) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (load) begin
        sreg_q <= byte_dat;
        left_q <= byte_bits;
      end else if (shift) begin
        sreg_q <= {sreg_q[6:0], 1'b0};
        left_q <= left_q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/minilogix_loader.sv
// Byte-stream to serial shift-load controller for one minilogix1 block; owns the
// load FSM, the image bit counter and the run-enable gate.
module minilogix_loader
  import minilogix_pkg::*;
#(
  parameter int unsigned NIN  = 8,
  parameter int unsigned NOUT = 8,
  parameter int unsigned HALF = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [7:0] i_byte_dat,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  output logic       o_load_en,
  output logic       o_load_clk,
  output logic       o_load_dat,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_cfg_valid,
  output logic       o_run_en
);

  localparam int unsigned NBITS = calc_nbits(NIN, NOUT);
  localparam int unsigned REM   = calc_rem(NBITS);
  localparam int unsigned CntW  = $clog2(NBITS + 1);
  localparam logic [CntW-1:0] BitsTotal  = CntW'(NBITS);
  localparam logic [CntW-1:0] LastByteAt = CntW'(NBITS - REM);
  localparam logic [3:0]      RemBits    = 4'(REM);

  state_e          state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic            cfg_valid_q, cfg_valid_d;
  logic            busy_q, clk_q, dat_q, ready_q, done_q;
  logic            accept, run, shift, phase_end, msb_next, last_bit;
  logic [3:0]      byte_bits;

  // Abort must win over a same-cycle handshake, so ready is gated combinationally.
  assign o_byte_ready = ready_q & ~i_abort;
  assign accept       = i_byte_valid & o_byte_ready;
  assign run          = ((state_q == StShiftLo) || (state_q == StShiftHi)) && !i_abort;
  assign shift        = phase_end && (state_q == StShiftHi);
  assign byte_bits    = ((REM != 0) && (bit_cnt_q == LastByteAt)) ? RemBits : 4'd8;

  minilogix_ser #(
    .HALF(HALF)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .load     (accept),
    .byte_dat (i_byte_dat),
    .byte_bits(byte_bits),
    .shift    (shift),
    .phase_end(phase_end),
    .msb_next (msb_next),
    .last_bit (last_bit)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cfg_valid_d = cfg_valid_q;
    if (i_abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      cfg_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start && !i_abort) begin
            state_d     = StWaitByte;
            bit_cnt_d   = '0;
            cfg_valid_d = 1'b0;
          end
        end
        StWaitByte: if (accept) state_d = StShiftLo;
        StShiftLo:  if (phase_end) state_d = StShiftHi;
        StShiftHi: begin
          if (phase_end) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_d == BitsTotal) begin
              state_d     = StDone;
              cfg_valid_d = 1'b1;
            end else if (last_bit) begin
              state_d = StWaitByte;
            end else begin
              state_d = StShiftLo;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      cfg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      clk_q       <= 1'b0;
      dat_q       <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cfg_valid_q <= cfg_valid_d;
      busy_q      <= (state_d == StWaitByte) || (state_d == StShiftLo) || (state_d == StShiftHi);
      clk_q       <= (state_d == StShiftHi);
      ready_q     <= (state_d == StWaitByte);
      done_q      <= (state_d == StDone);
      if (state_d == StIdle) begin
        dat_q <= 1'b0;
      end else if ((state_d == StShiftLo) && (state_q != StShiftLo)) begin
        dat_q <= msb_next;
      end
    end
  end

  assign o_busy      = busy_q;
  assign o_load_en   = busy_q;
  assign o_load_clk  = clk_q;
  assign o_load_dat  = dat_q;
  assign o_done      = done_q;
  assign o_cfg_valid = cfg_valid_q;
  assign o_run_en    = cfg_valid_q;

endmodule

// File: tb/tb_minilogix_loader.sv
// Bench for minilogix_loader: a small (2x2, HALF=3) and a default (8x8, HALF=1)
// instance, each checked against a shift-register model of the attached block.
module tb_minilogix_loader;

  localparam int SH    = 3;    // small instance load-clock half period
  localparam int SBITS = 10;   // 2*2**2 + 2
  localparam int DBITS = 2056; // 8*2**8 + 8
  localparam int DBYTES = 257;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic s_rst_n = 1'b1, s_start = 1'b0, s_abort = 1'b0, s_byte_valid = 1'b0;
  logic [7:0] s_byte_dat = '0;
  logic s_byte_ready, s_load_en, s_load_clk, s_load_dat, s_busy, s_done, s_cfg_valid, s_run_en;
  logic d_rst_n = 1'b1, d_start = 1'b0, d_abort = 1'b0, d_byte_valid = 1'b0;
  logic [7:0] d_byte_dat = '0;
  logic d_byte_ready, d_load_en, d_load_clk, d_load_dat, d_busy, d_done, d_cfg_valid, d_run_en;

  minilogix_loader #(.NIN(2), .NOUT(2), .HALF(SH)) u_small (
    .clk(clk), .rst_n(s_rst_n), .i_start(s_start), .i_abort(s_abort),
    .i_byte_dat(s_byte_dat), .i_byte_valid(s_byte_valid), .o_byte_ready(s_byte_ready),
    .o_load_en(s_load_en), .o_load_clk(s_load_clk), .o_load_dat(s_load_dat),
    .o_busy(s_busy), .o_done(s_done), .o_cfg_valid(s_cfg_valid), .o_run_en(s_run_en)
  );

  minilogix_loader #(.NIN(8), .NOUT(8), .HALF(1)) u_dflt (
    .clk(clk), .rst_n(d_rst_n), .i_start(d_start), .i_abort(d_abort),
    .i_byte_dat(d_byte_dat), .i_byte_valid(d_byte_valid), .o_byte_ready(d_byte_ready),
    .o_load_en(d_load_en), .o_load_clk(d_load_clk), .o_load_dat(d_load_dat),
    .o_busy(d_busy), .o_done(d_done), .o_cfg_valid(d_cfg_valid), .o_run_en(d_run_en)
  );

  int errors = 0, checks = 0, cyc = 0;
  int s_acc = 0, d_acc = 0, s_rises = 0, d_rises = 0;
  int s_hi_len = 0, s_dat_age = 0, s_phase_bad = 0;
  logic s_hs, d_hs, s_prev = 1'b0, d_prev = 1'b0, s_prev_dat = 1'b0;
  logic [SBITS-1:0] s_cap = '0;  // model of the block's config shift chain
  logic [DBITS-1:0] d_cap = '0;

  function automatic logic [7:0] s_outs();
    return {s_busy, s_load_en, s_load_clk, s_load_dat, s_byte_ready, s_done, s_cfg_valid,
            s_run_en};
  endfunction

  function automatic logic [7:0] d_outs();
    return {d_busy, d_load_en, d_load_clk, d_load_dat, d_byte_ready, d_done, d_cfg_valid,
            d_run_en};
  endfunction

  // Advance one cycle; handshakes are judged from inputs settled before the edge.
  task automatic step();
    #1;
    s_hs = s_byte_valid && s_byte_ready;
    d_hs = d_byte_valid && d_byte_ready;
    @(negedge clk);
    cyc++;
    if (s_hs) s_acc++;
    if (d_hs) d_acc++;
    if (s_load_dat == s_prev_dat) s_dat_age++;
    else s_dat_age = 1;
    if (s_load_clk && !s_prev) begin
      s_rises++;
      s_cap = {s_cap[SBITS-2:0], s_load_dat};
      if (s_dat_age < SH + 1) s_phase_bad++;
      s_hi_len = 1;
    end else if (s_load_clk) begin
      s_hi_len++;
      if (s_load_dat != s_prev_dat) s_phase_bad++;
    end else if (s_prev && s_hi_len != SH) begin
      s_phase_bad++;
    end
    s_prev = s_load_clk;
    s_prev_dat = s_load_dat;
    if (d_load_clk && !d_prev) begin
      d_rises++;
      d_cap = {d_cap[DBITS-2:0], d_load_dat};
    end
    d_prev = d_load_clk;
  endtask

  task automatic s_start_load();
    s_rises = 0;
    s_cap = '0;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
  endtask

  task automatic s_send(input logic [7:0] b);
    int n;
    n = s_acc;
    s_byte_dat = b;
    s_byte_valid = 1'b1;
    for (int i = 0; i < 200 && s_acc == n; i++) step();
    s_byte_valid = 1'b0;
    if (s_acc == n) begin
      errors++; checks++;
      $display("FAIL s_send timeout: accepted=%0d required=%0d", s_acc, n + 1);
    end
  endtask

  task automatic s_wait_done(output int pulses);
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (s_done) pulses++;
    end
  endtask

  // Expected chain contents: first SBITS bits of the two-byte stream, MSB first.
  function automatic logic [SBITS-1:0] s_expect(input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] w;
    w = {b0, b1};
    return w[15:16-SBITS];
  endfunction

  task automatic test_reset();
    s_rst_n = 1'b0; d_rst_n = 1'b0;
    step(); step();
    checks++; if (s_outs() !== 8'h00) begin errors++; $display("FAIL reset_small: got %b want 0", s_outs()); end
    checks++; if (d_outs() !== 8'h00) begin errors++; $display("FAIL reset_dflt: got %b want 0", d_outs()); end
    s_rst_n = 1'b1; d_rst_n = 1'b1;
    step();
    checks++; if (s_outs() !== 8'h00) begin errors++; $display("FAIL idle_small: got %b want 0", s_outs()); end
  endtask

  task automatic test_load_a5c0();
    int p;
    s_phase_bad = 0;
    s_start_load();
    checks++;
    if ({s_busy, s_load_en, s_byte_ready, s_cfg_valid} !== 4'b1110) begin
      errors++; $display("FAIL start_outputs: got %b want 1110", {s_busy, s_load_en, s_byte_ready, s_cfg_valid});
    end
    s_send(8'hA5);
    s_send(8'hC0);
    s_wait_done(p);
    checks++; if (s_rises != SBITS) begin errors++; $display("FAIL a5c0_rises: got %0d want %0d", s_rises, SBITS); end
    checks++; if (s_cap !== s_expect(8'hA5, 8'hC0)) begin errors++; $display("FAIL a5c0_image: got %b want %b", s_cap, s_expect(8'hA5, 8'hC0)); end
    checks++; if (p != 1) begin errors++; $display("FAIL a5c0_done_pulses: got %0d want 1", p); end
    checks++;
    if ({s_cfg_valid, s_run_en, s_busy, s_load_en} !== 4'b1100) begin
      errors++; $display("FAIL a5c0_final: got %b want 1100", {s_cfg_valid, s_run_en, s_busy, s_load_en});
    end
    checks++; if (s_phase_bad != 0) begin errors++; $display("FAIL half3_phases: got %0d bad phases want 0", s_phase_bad); end
  endtask

  task automatic test_withhold();
    logic [7:0] b0, b1;
    int bad, p, w;
    b0 = 8'($urandom); b1 = 8'($urandom);
    s_start_load();
    s_send(b0);
    for (w = 0; w < 200 && !s_byte_ready; w++) step();
    checks++; if (!s_byte_ready) begin errors++; $display("FAIL withhold_ready: got 0 want 1"); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_load_clk || !s_load_en) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL withhold_idle: got %0d bad cycles want 0", bad); end
    checks++; if (s_rises != 8) begin errors++; $display("FAIL withhold_rises: got %0d want 8", s_rises); end
    s_send(b1);
    s_wait_done(p);
    checks++; if (s_cap !== s_expect(b0, b1) || p != 1) begin
      errors++; $display("FAIL withhold_image: got %b/%0d want %b/1", s_cap, p, s_expect(b0, b1));
    end
  endtask

  task automatic test_abort();
    logic [7:0] b0, b1;
    int n, p;
    b0 = 8'($urandom); b1 = 8'($urandom);
    s_start_load();
    s_send(b0);
    for (int i = 0; i < 100 && s_rises < 5; i++) step();
    s_abort = 1'b1; s_byte_valid = 1'b1; s_byte_dat = b1; n = s_acc;
    step();
    s_abort = 1'b0; s_byte_valid = 1'b0;
    checks++; if (s_outs() !== 8'h00) begin errors++; $display("FAIL abort_shift: got %b want 0", s_outs()); end
    checks++; if (s_rises != 5) begin errors++; $display("FAIL abort_rises: got %0d want 5", s_rises); end
    s_start_load();
    s_abort = 1'b1; s_byte_valid = 1'b1; n = s_acc;
    step();
    s_abort = 1'b0; s_byte_valid = 1'b0;
    checks++; if (s_acc != n) begin errors++; $display("FAIL abort_byte_consumed: got %0d want %0d", s_acc, n); end
    checks++; if (s_outs() !== 8'h00) begin errors++; $display("FAIL abort_wait: got %b want 0", s_outs()); end
    s_start = 1'b1; s_abort = 1'b1;
    step();
    s_start = 1'b0; s_abort = 1'b0;
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL start_abort_idle: got %b want 0", s_busy); end
    b0 = 8'($urandom); b1 = 8'($urandom);
    s_start_load();
    s_send(b0);
    s_send(b1);
    s_wait_done(p);
    checks++; if (s_cap !== s_expect(b0, b1) || !s_cfg_valid || p != 1) begin
      errors++; $display("FAIL abort_reload: got %b/%b/%0d want %b/1/1", s_cap, s_cfg_valid, p, s_expect(b0, b1));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b0, b1;
    int p;
    b0 = 8'($urandom); b1 = 8'($urandom);
    s_start_load();
    s_send(b0);
    for (int i = 0; i < 100 && !s_load_clk; i++) step();
    s_rst_n = 1'b0;
    #2;
    checks++; if (s_outs() !== 8'h00) begin errors++; $display("FAIL async_reset: got %b want 0", s_outs()); end
    step();
    s_rst_n = 1'b1;
    step();
    checks++; if (s_outs() !== 8'h00) begin errors++; $display("FAIL reset_release: got %b want 0", s_outs()); end
    s_start_load();
    s_send(b0);
    for (int i = 0; i < 100 && s_rises < 3; i++) step();
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", s_busy); end
    s_send(b1);
    s_wait_done(p);
    checks++; if (s_rises != SBITS || s_cap !== s_expect(b0, b1) || p != 1) begin
      errors++; $display("FAIL start_ignored: got %0d/%b/%0d want %0d/%b/1", s_rises, s_cap, p, SBITS, s_expect(b0, b1));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] img [DBYTES];
    logic [DBITS-1:0] exp_img;
    int t_ready, t_done, pulses;
    for (int i = 0; i < DBYTES; i++) img[i] = 8'($urandom);
    img[0] = 8'h00;  // select word 0: plain input addressing
    exp_img = '0;
    for (int i = 0; i < DBYTES; i++) exp_img = {exp_img[DBITS-9:0], img[i]};
    t_ready = -1; t_done = -1; pulses = 0; d_rises = 0; d_cap = '0;
    d_start = 1'b1;
    step();
    d_start = 1'b0;
    if (d_byte_ready) t_ready = cyc;
    d_byte_valid = 1'b1;
    d_byte_dat = img[0];
    for (int c = 0; c < 6000 && !(t_done >= 0 && cyc > t_done + 4); c++) begin
      step();
      if (d_byte_ready && t_ready < 0) t_ready = cyc;
      if (d_done) begin
        pulses++;
        if (t_done < 0) t_done = cyc;
      end
      if (d_acc < DBYTES) d_byte_dat = img[d_acc];
      else d_byte_valid = 1'b0;
    end
    d_byte_valid = 1'b0;
    checks++; if (t_ready < 0 || t_done - t_ready != 4369) begin
      errors++; $display("FAIL b2b_latency: got %0d cycles want 4369", t_done - t_ready);
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d want 1", pulses); end
    checks++; if (d_rises != DBITS) begin errors++; $display("FAIL b2b_rises: got %0d want %0d", d_rises, DBITS); end
    checks++; if (d_cap !== exp_img) begin
      errors++; $display("FAIL b2b_image: got low %h want low %h", d_cap[63:0], exp_img[63:0]);
    end
    // RAM word 0x3C sits after the select byte and words 255..61 in the stream.
    checks++; if (d_cap[8*8'h3C +: 8] !== img[1 + 255 - 8'h3C]) begin
      errors++; $display("FAIL b2b_word_3c: got %h want %h", d_cap[8*8'h3C +: 8], img[1 + 255 - 8'h3C]);
    end
    checks++; if ({d_cfg_valid, d_run_en, d_busy} !== 3'b110) begin
      errors++; $display("FAIL b2b_final: got %b want 110", {d_cfg_valid, d_run_en, d_busy});
    end
  endtask

  initial begin
    test_reset();
    test_load_a5c0();
    test_withhold();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
